// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined RV32I control decoder.
//
// Decodes the instruction in ID into a 12-bit control bundle. The bundle and
// its rd then travel through NUM_STAGES registered stages: stage 0 is EX,
// followed by MEM, WB and so on. The block also provides a global stall, a
// flush that turns the ID slot into a bubble, and load-use hazard detection.
//
// Bundle layout:
//   [0] rd_write  [1] br_type  [3:2] taken  [4] b_sel  [5] d_we
//   [6] dcache_re [8:7] wb_sel [9] csr_load [10] illegal [11] valid
//
// Ports:
//   clk          in   clock; every state update happens on the rising edge
//   reset        in   synchronous active-low reset
//   instr        in   instruction currently in ID
//   instr_valid  in   instr is valid this cycle
//   stall        in   freeze all stages
//   flush        in   kill ID and stage 0 (branch redirect)
//   ctrl_bus     out  per-stage bundles; stage k is at [12k+11:12k]
//   rd_bus       out  per-stage rd; stage k is at [RA_W*k+RA_W-1:RA_W*k]
//   hazard_stall out  combinational load-use hazard; upstream holds ID
//   id_illegal   out  combinational; the valid ID instruction is undecodable
//
// Optional feature: when CTRL_PIPE_CSR_EN is defined, the CSR opcode is
// decoded. Otherwise the CSR opcode is treated as illegal.

module ctrl_pipe #(
  parameter int NUM_STAGES = 3,
  parameter int INSTR_W    = 32,
  parameter int RA_W       = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INSTR_W-1:0]         instr,
  input  logic                       instr_valid,
  input  logic                       stall,
  input  logic                       flush,
  output logic [NUM_STAGES*12-1:0]   ctrl_bus,
  output logic [NUM_STAGES*RA_W-1:0] rd_bus,
  output logic                       hazard_stall,
  output logic                       id_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [RA_W-1:0] id_rd;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign id_rd  = RA_W'(instr[11:7]);
  assign id_rs1 = RA_W'(instr[19:15]);
  assign id_rs2 = RA_W'(instr[24:20]);

  // The funct7 / immediate bits do not influence control decode.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr[INSTR_W-1:25]};

  logic [11:0]     id_ctrl;
  logic [RA_W-1:0] id_rd_val;
  logic            dec_illegal;
  logic            uses_rs1;
  logic            uses_rs2;

  // Opcode decode. Any field that an opcode does not mention stays 0.
  // An invalid ID slot produces an all-zero bundle and a zero rd.
  always_comb begin
    logic       rd_write;
    logic       br_type;
    logic [1:0] taken;
    logic       b_sel;
    logic       d_we;
    logic       dcache_re;
    logic [1:0] wb_sel;
    logic       csr_load;

    rd_write    = 1'b0;
    br_type     = 1'b0;
    taken       = 2'd0;
    b_sel       = 1'b0;
    d_we        = 1'b0;
    dcache_re   = 1'b0;
    wb_sel      = 2'd0;
    csr_load    = 1'b0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;

    case (opcode)
      OP_LUI: begin
        rd_write = 1'b1;
        b_sel    = 1'b1;
      end
      OP_AUIPC: begin
        rd_write = 1'b1;
        b_sel    = 1'b1;
        wb_sel   = 2'd3;
      end
      OP_BRANCH: begin
        taken    = 2'd1;
        // BNE, BLT and BLTU use the inverted comparison result.
        br_type  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LOAD: begin
        rd_write  = 1'b1;
        b_sel     = 1'b1;
        dcache_re = 1'b1;
        wb_sel    = 2'd1;
        uses_rs1  = 1'b1;
      end
      OP_STORE: begin
        b_sel    = 1'b1;
        d_we     = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        rd_write = 1'b1;
        b_sel    = 1'b1;
        taken    = 2'd2;
        wb_sel   = 2'd2;
      end
      OP_JALR: begin
        rd_write = 1'b1;
        b_sel    = 1'b1;
        taken    = 2'd3;
        wb_sel   = 2'd2;
        uses_rs1 = 1'b1;
      end
      OP_ITYPE: begin
        rd_write = 1'b1;
        b_sel    = 1'b1;
        uses_rs1 = 1'b1;
      end
      OP_RTYPE: begin
        rd_write = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_CSR: begin
        // Register-source CSR forms (funct3[2]=0) read rs1 whether or not
        // the CSR path itself is enabled.
        uses_rs1 = ~funct3[2];
`ifdef CTRL_PIPE_CSR_EN
        csr_load = 1'b1;
        b_sel    = 1'b1;
        rd_write = 1'b1;
`else
        dec_illegal = 1'b1;
`endif
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase

    // Writes to x0 are architecturally discarded, so never request them.
    if (id_rd == '0) begin
      rd_write = 1'b0;
    end

    if (instr_valid) begin
      id_ctrl   = {1'b1, dec_illegal, csr_load, wb_sel, dcache_re, d_we,
                   b_sel, taken, br_type, rd_write};
      id_rd_val = id_rd;
    end else begin
      id_ctrl   = '0;
      id_rd_val = '0;
    end
  end

  logic [11:0]     stage_ctrl [NUM_STAGES];
  logic [RA_W-1:0] stage_rd   [NUM_STAGES];

  // Load-use hazard: the instruction in EX is a load whose result is not
  // yet available, and the ID instruction reads the loaded register.
  logic s0_is_load;
  assign s0_is_load = stage_ctrl[0][11] & stage_ctrl[0][6] & stage_ctrl[0][0]
                    & (stage_rd[0] != '0);

  assign hazard_stall = s0_is_load & instr_valid
                      & ((uses_rs1 & (id_rs1 == stage_rd[0]))
                       | (uses_rs2 & (id_rs2 == stage_rd[0])));

  assign id_illegal = instr_valid & dec_illegal;

  // Stage registers. Update priority is reset, then stall, then bubble
  // insertion (flush or hazard), then the normal shift. The downstream
  // stages always shift unless the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_ctrl[k] <= '0;
        stage_rd[k]   <= '0;
      end
    end else if (!stall) begin
      if (flush || hazard_stall) begin
        stage_ctrl[0] <= '0;
        stage_rd[0]   <= '0;
      end else begin
        stage_ctrl[0] <= id_ctrl;
        stage_rd[0]   <= id_rd_val;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        stage_ctrl[k] <= stage_ctrl[k-1];
        stage_rd[k]   <= stage_rd[k-1];
      end
    end
  end

  // Flatten the per-stage registers onto the output buses.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_pack
    assign ctrl_bus[12*g +: 12]    = stage_ctrl[g];
    assign rd_bus[RA_W*g +: RA_W]  = stage_rd[g];
  end

endmodule
